// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: request/acknowledge data bus between the MEM-stage controller and memory
interface mem_bus_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                bus_req_o;
  logic                bus_we_o;
  logic [ADDR_W-1:0]   bus_addr_o;
  logic [DATA_W-1:0]   bus_wdata_o;
  logic [DATA_W/8-1:0] bus_sel_o;
  logic                bus_ack_i;
  logic [DATA_W-1:0]   bus_rdata_i;
  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o,
    input  bus_ack_i, bus_rdata_i
  );
  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: MEM-stage load/store controller with big-endian lanes, LL/SC link bit and bus timeout
module mem_bus_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_sign_i,
  input  logic              req_ll_i,
  input  logic              req_sc_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic              llbit_clr_i,
  output logic              stall_o,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              exc_adel_o,
  output logic              exc_ades_o,
  output logic              exc_bus_o,
  output logic              llbit_o,
  mem_bus_ctrl_if.master    bus
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  state_t state, state_n;
  logic [15:0] cnt;
  logic we_r, sign_r, ll_r, sc_r, adel_r, ades_r, ebus_r, llbit;
  logic [1:0] size_r;
  logic [OW-1:0] off, off_r;
  logic [DATA_W-1:0] rdata_r, wdata_n, sh, ld;
  logic signed [DATA_W-1:0] lds;
  logic [NB-1:0] sel_n;
  logic misal, sc_fail, accept, to_hit;
  int sa;
  assign off = req_addr_i[OW-1:0];
  assign accept = state == IDLE && req_valid_i;
  assign sc_fail = req_sc_i && !llbit;
  assign to_hit = cnt == 16'(TIMEOUT - 1);
  // request decode: alignment, contiguous MSB-first byte lanes and replicated store data
  always_comb begin
    misal = req_size_i == 2'd1 ? off[0] :
            req_size_i == 2'd2 ? |off[1:0] :
            req_size_i == 2'd3 ? (DATA_W != 64) || |off : 1'b0;
    sel_n = ~({NB{1'b1}} >> (1 << req_size_i)) >> off;
    wdata_n = req_size_i == 2'd0 ? {NB{req_wdata_i[7:0]}} :
              req_size_i == 2'd1 ? {(NB/2){req_wdata_i[15:0]}} :
              req_size_i == 2'd2 ? {(NB/4){req_wdata_i[31:0]}} : req_wdata_i;
  end
  // load alignment: move the addressed lanes to the top, then shift down with zero/sign fill
  always_comb begin
    sh = bus.bus_rdata_i << {off_r, 3'b000};
    sa = size_r == 2'd3 ? 0 : DATA_W - (8 << size_r);
    lds = $signed(sh) >>> sa;
    ld = sign_r ? $unsigned(lds) : sh >> sa;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next state: faults and failed SCs skip the bus entirely
  always_comb begin
    state_n = state == IDLE ? (req_valid_i ? ((misal || sc_fail) ? DONE : BUS) : IDLE) :
              state == BUS  ? ((bus.bus_ack_i || to_hit) ? DONE : BUS) : IDLE;
  end
  // pipeline-facing outputs; response fields are only meaningful during DONE
  always_comb begin
    stall_o = accept || state == BUS;
    rsp_valid_o = state == DONE;
    rsp_rdata_o = state == DONE ? rdata_r : '0;
    exc_adel_o = state == DONE && adel_r;
    exc_ades_o = state == DONE && ades_r;
    exc_bus_o = state == DONE && ebus_r;
    llbit_o = llbit;
  end
  // request capture, registered bus drive, timeout counter and response data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {we_r, sign_r, ll_r, sc_r, adel_r, ades_r, ebus_r} <= '0;
      size_r <= '0;
      off_r <= '0;
      rdata_r <= '0;
      cnt <= '0;
      bus.bus_req_o <= 1'b0;
      bus.bus_we_o <= 1'b0;
      bus.bus_addr_o <= '0;
      bus.bus_wdata_o <= '0;
      bus.bus_sel_o <= '0;
    end else if (accept) begin
      we_r <= req_we_i;
      sign_r <= req_sign_i;
      ll_r <= req_ll_i;
      sc_r <= req_sc_i;
      size_r <= req_size_i;
      off_r <= off;
      adel_r <= misal && !req_we_i;
      ades_r <= misal && req_we_i;
      ebus_r <= 1'b0;
      rdata_r <= '0;
      cnt <= '0;
      bus.bus_req_o <= state_n == BUS;
      bus.bus_we_o <= req_we_i;
      bus.bus_addr_o <= {req_addr_i[ADDR_W-1:OW], OW'(0)};
      bus.bus_wdata_o <= wdata_n;
      bus.bus_sel_o <= sel_n;
    end else if (state == BUS) begin
      cnt <= cnt + 16'd1;
      if (bus.bus_ack_i) begin
        bus.bus_req_o <= 1'b0;
        rdata_r <= sc_r ? DATA_W'(1) : we_r ? '0 : ld;
      end else if (to_hit) begin
        bus.bus_req_o <= 1'b0;
        ebus_r <= 1'b1;
      end
    end
  // link bit: an acked LL sets it, an acked SC clears it, an explicit clear beats both
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) llbit <= 1'b0;
    else if (llbit_clr_i) llbit <= 1'b0;
    else if (state == BUS && bus.bus_ack_i && (ll_r || sc_r)) llbit <= ll_r;
endmodule
